// File: rtl/adc_sample_averager.sv
// Averages fixed windows of 2^LOG2_N ADC conversion results and publishes
// the rounded mean plus the window minimum and maximum once per window.
module adc_sample_averager #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] avg,
    output logic [DATA_W-1:0] avg_min,
    output logic [DATA_W-1:0] avg_max,
    output logic              avg_valid,
    output logic [LOG2_N-1:0] fill
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [LOG2_N-1:0] FILL_LAST = '1;
    localparam logic [SUM_W-1:0]  HALF      = SUM_W'(2 ** (LOG2_N - 1));

    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] next_min;
    logic [DATA_W-1:0] next_max;
    logic [DATA_W-1:0] rounded;
    logic [SUM_W-1:0]  sum;
    logic              completes;

    // Fold the incoming sample into the running statistics; sum is one bit
    // wider than acc so the rounding constant can never wrap.
    always_comb begin
        next_min  = (sample < run_min) ? sample : run_min;
        next_max  = (sample > run_max) ? sample : run_max;
        sum       = {1'b0, acc} + SUM_W'(sample) + HALF;
        rounded   = DATA_W'(sum >> LOG2_N);
        completes = sample_valid && (fill == FILL_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            fill      <= '0;
            run_min   <= '1;
            run_max   <= '0;
            avg       <= '0;
            avg_min   <= '0;
            avg_max   <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            // A coincident sample starts the fresh window rather than completing the old one.
            if (clear) begin
                if (sample_valid) begin
                    acc     <= ACC_W'(sample);
                    fill    <= LOG2_N'(1);
                    run_min <= sample;
                    run_max <= sample;
                end else begin
                    acc     <= '0;
                    fill    <= '0;
                    run_min <= '1;
                    run_max <= '0;
                end
            end else if (completes) begin
                avg       <= rounded;
                avg_min   <= next_min;
                avg_max   <= next_max;
                avg_valid <= 1'b1;
                acc       <= '0;
                fill      <= '0;
                run_min   <= '1;
                run_max   <= '0;
            end else if (sample_valid) begin
                acc     <= acc + ACC_W'(sample);
                fill    <= fill + LOG2_N'(1);
                run_min <= next_min;
                run_max <= next_max;
            end
        end
    end

endmodule

// File: doc/adc_sample_averager.md
# adc_sample_averager

Downstream stage of the successive-approximation ADC path. It takes each finished 8-bit conversion result from the binary-search converter and accumulates a fixed window of 2^LOG2_N samples. At the end of each window it publishes the rounded mean together with the window minimum and maximum. It turns a noisy per-conversion code into a stable reading for display and logging logic.

## Interface

Parameters:
- DATA_W, default 8: sample width; matches the converter result width.
- LOG2_N, default 3: log2 of the window length N. Legal range is 1..6.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- sample  input  DATA_W  conversion result; valid only when sample_valid=1.
- sample_valid  input  1  one-cycle strobe; the upstream side asserts it for each new conversion result.
- clear  input  1  synchronous window restart.
- avg  output  DATA_W  rounded mean of the last complete window.
- avg_min  output  DATA_W  minimum sample in the last complete window.
- avg_max  output  DATA_W  maximum sample in the last complete window.
- avg_valid  output  1  one-cycle pulse when avg, avg_min and avg_max update.
- fill  output  LOG2_N  number of samples accepted in the current, incomplete window.

## Operation

Reset (rst=0 at an edge):
- acc, fill, avg, avg_min, avg_max and avg_valid are all 0.
- The running minimum becomes all-ones and the running maximum becomes 0.
- Reset takes priority over every other input.

Sample acceptance:
- A sample is accepted on any edge with rst=1 and sample_valid=1.
- Gaps of any length between strobes are allowed; fill only counts accepted samples.

Accumulator:
- acc is DATA_W+LOG2_N bits wide and cannot overflow.
- On each accepted sample, acc <= acc + sample, run_min <= min(run_min, sample), run_max <= max(run_max, sample).

Window completion (accepted sample with fill = N-1):
- avg <= (acc + sample + 2^(LOG2_N-1)) >> LOG2_N, i.e. round-half-up.
- The sum is computed DATA_W+LOG2_N+1 bits wide. The result never exceeds 2^DATA_W-1.
- avg_min and avg_max load from the running values, including the completing sample.
- avg_valid <= 1.
- acc, fill, run_min and run_max return to their reset values.
- fill wraps from N-1 to 0.

Other edges:
- avg_valid <= 0 on every edge that does not complete a window.
- avg, avg_min and avg_max hold their values between completions.

Clear:
- clear=1 discards the partial window: acc, fill, run_min and run_max return to reset values.
- avg, avg_min and avg_max are not modified.
- If clear=1 and sample_valid=1 on the same edge, clear is applied first. The coincident sample becomes the first sample of the new window (fill=1).
- In that case no completion occurs, even if fill was N-1.

State machine: none beyond the fill counter. The block is always in ACCUM; completion is a single-edge event.

## Timing

- Latency: avg, avg_min, avg_max and avg_valid are visible immediately after the edge that accepts the Nth sample. That is one edge of latency, with no extra pipeline stage.
- avg_valid is high for exactly one cycle per completed window.
- Back-to-back windows are supported at full rate, one sample per cycle. With continuous strobes, avg_valid pulses every N cycles.
- fill is combinationally equal to the registered counter and updates on the same edge as acceptance.
- A reset asserted mid-window aborts it; no avg_valid pulse is produced for the partial window.
- After reset is released, the first accepted sample gives fill=1.
- No combinational path exists from inputs to outputs.

## Test plan

All scenarios use LOG2_N=3 (N=8), DATA_W=8.

1. Reset, then 8 consecutive strobes of sample=100 -> single avg_valid pulse after the 8th, with avg=100, avg_min=100, avg_max=100; fill sequence 1..7 then 0.
2. Samples 0,1,…,7 with random 0–5 cycle gaps between strobes -> sum 28, avg=(28+4)>>3=4, avg_min=0, avg_max=7; no avg_valid before the 8th sample.
3. 8 samples of 255, then 8 samples of 0 back-to-back -> first pulse avg=255/min=255/max=255; pulse exactly 8 cycles later avg=0/min=0/max=0.
4. 5 samples of 50, then clear with a simultaneous sample=10, then 7 samples of 10:
   - fill=1 after the clear edge.
   - The pulse comes on the 7th following sample, with avg=10, min=10, max=10.
   - The earlier avg stays unchanged until that pulse.
5. 6 samples accepted, then rst=0 for one edge -> fill=0, avg=0, avg_valid never pulses. Then 8 samples of 3 -> avg=3.
6. Rounding boundary: samples summing to 12 (e.g. 1,1,1,1,2,2,2,2) -> (12+4)>>3=2. Samples summing to 11 -> (11+4)>>3=1.
